gate_primitive_unit: RTL and testbench
======================================

Name: gate_primitive_unit

Overview:
- Bit-parallel primitive-gate block providing AND (a & b), NOT (~a) and XOR (a ^ b) on WIDTH-bit operands.
- Supplies both a combinational path, used when composing gate-level structures such as a half subtractor (diff = a ^ b, borrow = ~a & b), and a registered path with a valid flag for pipelined use.
- Sits at leaf level; higher blocks instantiate it in place of discrete gates.

Parameters:
- WIDTH, 1, operand/result width in bits; every gate operates bitwise per lane, with no carry or borrow between lanes.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  WIDTH  operand A; the only NOT input
- b  input  WIDTH  operand B
- in_valid  input  1  capture strobe for registered outputs
- and_c  output  WIDTH  combinational a & b
- not_c  output  WIDTH  combinational ~a
- xor_c  output  WIDTH  combinational a ^ b
- and_q  output  WIDTH  registered a & b
- not_q  output  WIDTH  registered ~a
- xor_q  output  WIDTH  registered a ^ b
- out_valid  output  1  high for one cycle after a captured in_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Combinational outputs:
  - and_c, not_c and xor_c follow a and b with zero latency, independent of clk, rst and in_valid.
  - Truth table per bit (a, b -> and, not, xor): 00 -> 0,1,0; 01 -> 0,1,1; 10 -> 0,0,1; 11 -> 1,0,0.
- Registered outputs:
  - Updated only on the rising clk edge.
  - If rst=1: and_q, not_q, xor_q and out_valid all become 0. not_q resets to 0, not to ~0. rst has priority over in_valid.
  - Else if in_valid=1: and_q <= a & b, not_q <= ~a, xor_q <= a ^ b, out_valid <= 1.
  - Else: the three result registers hold their previous value and out_valid <= 0.
- Latency: exactly 1 cycle from a sampled in_valid to out_valid with matching results. Back-to-back in_valid gives one result per cycle, with no bubbles and no backpressure.
- Reset asserted mid-stream: the next edge clears all registers; an in_valid present on that edge is discarded.
- Reset release: the first edge with rst=0 and in_valid=1 produces valid data on the following cycle.
- Lanes are independent: bit i of every output depends only on a[i] and b[i].
- No X-propagation handling beyond standard operator semantics.
- No internal state other than the four registers.

Test Plan:
- WIDTH=1; with rst=0 apply (a,b) = 00, 01, 10, 11, each held 50 time units. Required combinational outputs (and, not, xor): 0,1,0 / 0,1,1 / 0,0,1 / 1,0,0. Derived borrow (not_c & b) = 0,1,0,0 and diff = xor_c.
- Assert rst for 2 cycles with a=1, b=1, in_valid=1 -> and_q=0, not_q=0, xor_q=0, out_valid=0 throughout. Deassert rst -> next cycle and_q=1, not_q=0, xor_q=0, out_valid=1.
- Drive in_valid on 4 consecutive cycles with (a,b) = 00, 01, 10, 11 -> registered outputs reproduce the truth table one cycle later, with out_valid=1 for 4 consecutive cycles.
- Capture a=1, b=0; then hold in_valid=0 while toggling a and b for 3 cycles -> and_q=0, not_q=0, xor_q=1 held; out_valid=0 after the first cycle; combinational outputs track the inputs.
- WIDTH=4: a=4'b1100, b=4'b1010, in_valid=1 -> and_q=4'b1000, not_q=4'b0011, xor_q=4'b0110 one cycle later.
- Assert rst together with in_valid=1 after a valid stream -> all registered outputs 0 on that edge, and no out_valid pulse for the discarded input.

Source files
------------

// File: rtl/gate_primitive_unit.sv
// gate_primitive_unit
// Leaf-level bit-parallel gate block: AND (a & b), NOT (~a) and XOR (a ^ b)
// on WIDTH-bit operands. Each lane is independent and has no carry or borrow.
// The block offers two copies of the results: a zero-latency combinational copy
// for gate-level composition, such as a half subtractor, and a registered copy
// with a valid flag for pipelined use.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset, which takes priority over in_valid
//   a, b       operands; a is the only NOT input
//   in_valid   capture strobe for the registered outputs
//   and_c      combinational a & b
//   not_c      combinational ~a
//   xor_c      combinational a ^ b
//   and_q      registered a & b
//   not_q      registered ~a; the reset value is 0, not ~0
//   xor_q      registered a ^ b
//   out_valid  high for exactly one cycle after each captured in_valid
module gate_primitive_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] and_c,
  output logic [WIDTH-1:0] not_c,
  output logic [WIDTH-1:0] xor_c,
  output logic [WIDTH-1:0] and_q,
  output logic [WIDTH-1:0] not_q,
  output logic [WIDTH-1:0] xor_q,
  output logic             out_valid
);

  // The combinational path ignores clk, rst and in_valid.
  assign and_c = a & b;
  assign not_c = ~a;
  assign xor_c = a ^ b;

  // The result registers hold their value while idle. out_valid is a one-cycle
  // pulse, so it clears on any cycle that has no capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      and_q     <= '0;
      not_q     <= '0;
      xor_q     <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      and_q     <= and_c;
      not_q     <= not_c;
      xor_q     <= xor_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gate_primitive_unit.sv
module tb_gate_primitive_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance u1 has WIDTH=1.
  logic       rst1, iv1;
  logic [0:0] a1, b1;
  logic [0:0] and_c1, not_c1, xor_c1, and_q1, not_q1, xor_q1;
  logic       ov1;

  // Instance u4 has WIDTH=4.
  logic       rst4, iv4;
  logic [3:0] a4, b4;
  logic [3:0] and_c4, not_c4, xor_c4, and_q4, not_q4, xor_q4;
  logic       ov4;

  gate_primitive_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst1), .a(a1), .b(b1), .in_valid(iv1),
    .and_c(and_c1), .not_c(not_c1), .xor_c(xor_c1),
    .and_q(and_q1), .not_q(not_q1), .xor_q(xor_q1), .out_valid(ov1)
  );

  gate_primitive_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst4), .a(a4), .b(b4), .in_valid(iv4),
    .and_c(and_c4), .not_c(not_c4), .xor_c(xor_c4),
    .and_q(and_q4), .not_q(not_q4), .xor_q(xor_q4), .out_valid(ov4)
  );

  int total = 0;
  int bad   = 0;
  bit done  = 0;

  // Each expected entry is packed as {and, not, xor}.
  logic [2:0]  q1[$];
  logic [11:0] q4[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The monitors pop one expected entry for each presented out_valid.
  always @(negedge clk) begin
    if (!done && ov1 === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL sb1_unexpected_valid: got out_valid=1 expected 0 at %0t", $time);
      end else begin
        logic [2:0] e;
        e = q1.pop_front();
        chk("sb1_result", {29'd0, and_q1, not_q1, xor_q1}, {29'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (!done && ov4 === 1'b1) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL sb4_unexpected_valid: got out_valid=1 expected 0 at %0t", $time);
      end else begin
        logic [11:0] e;
        e = q4.pop_front();
        chk("sb4_result", {20'd0, and_q4, not_q4, xor_q4}, {20'd0, e});
      end
    end
  end

  // Each drive task is entered just after a rising edge. It applies the inputs,
  // pushes the hand-computed expectation when a capture will happen, and then
  // waits past the capturing edge.
  task automatic drive1(input logic a, input logic b, input logic iv, input logic r,
                        input logic [2:0] exp);
    a1 = a; b1 = b; iv1 = iv; rst1 = r;
    if (iv && !r) q1.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic iv,
                        input logic [11:0] exp);
    a4 = a; b4 = b; iv4 = iv; rst4 = 1'b0;
    if (iv) q4.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic chk_regs1(input string name, input logic [2:0] exp, input logic ov);
    chk({name, "_regs"}, {29'd0, and_q1, not_q1, xor_q1}, {29'd0, exp});
    chk({name, "_ov"}, {31'd0, ov1}, {31'd0, ov});
  endtask

  // Truth-table vectors: {a, b} with the expected {and, not, xor}.
  logic [1:0] tt_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [2:0] tt_out [4] = '{3'b010, 3'b011, 3'b001, 3'b100};
  logic       tt_bor [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0;
    rst4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs1("reset_state", 3'b000, 1'b0);
    chk("reset_state4", {19'd0, and_q4, not_q4, xor_q4, ov4}, 32'd0);

    // Combinational truth table, with the half-subtractor borrow and diff.
    rst1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a1 = tt_in[i][1]; b1 = tt_in[i][0];
      #10;
      chk("comb_tt", {29'd0, and_c1, not_c1, xor_c1}, {29'd0, tt_out[i]});
      chk("borrow", {31'd0, not_c1 & b1}, {31'd0, tt_bor[i]});
      chk("diff", {31'd0, xor_c1}, {31'd0, tt_out[i][0]});
      #40;
    end
    @(posedge clk); #1;

    // Reset takes priority over in_valid for two cycles.
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 1'b1, 1'b1, 1'b1, 3'b000);
      chk_regs1("rst_hold", 3'b000, 1'b0);
    end
    drive1(1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
    chk_regs1("rst_release", 3'b100, 1'b1);

    // Back-to-back captures: the monitor must see four consecutive valid pulses.
    for (int i = 0; i < 4; i++) begin
      drive1(tt_in[i][1], tt_in[i][0], 1'b1, 1'b0, tt_out[i]);
      chk("stream_ov", {31'd0, ov1}, 32'd1);
    end

    // Capture 1,0, then keep the registers holding while the inputs toggle.
    drive1(1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
    drive1(1'b0, 1'b1, 1'b0, 1'b0, 3'b000);
    chk_regs1("hold1", 3'b001, 1'b0);
    chk("hold1_comb", {29'd0, and_c1, not_c1, xor_c1}, {29'd0, 3'b011});
    drive1(1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    chk_regs1("hold2", 3'b001, 1'b0);
    chk("hold2_comb", {29'd0, and_c1, not_c1, xor_c1}, {29'd0, 3'b100});
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    chk_regs1("hold3", 3'b001, 1'b0);
    chk("hold3_comb", {29'd0, and_c1, not_c1, xor_c1}, {29'd0, 3'b010});

    // Reset arriving mid-stream discards the in_valid that comes with it.
    drive1(1'b1, 1'b1, 1'b1, 1'b0, 3'b100);
    drive1(1'b0, 1'b1, 1'b1, 1'b0, 3'b011);
    drive1(1'b1, 1'b0, 1'b1, 1'b1, 3'b000);
    chk_regs1("mid_rst", 3'b000, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    chk_regs1("post_rst", 3'b000, 1'b0);

    // Multi-lane checks on the WIDTH=4 instance.
    drive4(4'b1100, 4'b1010, 1'b1, {4'b1000, 4'b0011, 4'b0110});
    chk("w4_comb", {20'd0, and_c4, not_c4, xor_c4}, {20'd0, 4'b1000, 4'b0011, 4'b0110});
    drive4(4'b0101, 4'b0011, 1'b1, {4'b0001, 4'b1010, 4'b0110});
    drive4(4'b1111, 4'b0000, 1'b0, 12'd0);
    chk("w4_hold", {20'd0, and_q4, not_q4, xor_q4}, {20'd0, 4'b0001, 4'b1010, 4'b0110});
    chk("w4_ov", {31'd0, ov4}, 32'd0);

    @(posedge clk); #1;
    done = 1;
    chk("sb1_drained", q1.size(), 32'd0);
    chk("sb4_drained", q4.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the run ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule
